// File: rtl/gpio_pulse_monitor_if.sv
// ---------------------------------------------------------------------------
// gpio_pulse_monitor_if
//
// Bundles the control, monitored bus and event report signals of
// gpio_pulse_monitor. Clock and reset stay plain module ports.
//
//   start          : one-cycle arm request            (master -> slave)
//   abort          : synchronous return to idle       (master -> slave)
//   bus_in         : monitored GPIO/LED bus           (master -> slave)
//   event_valid    : one-cycle pulse per counted change
//   event_data     : bus value after the change
//   event_index    : 1-based ordinal of the change
//   event_interval : cycles since previous counted change (saturating)
//   busy           : monitor armed / counting
//   pass           : sticky, target number of changes seen
//   fail           : sticky, activity timeout
//
// master : the side that drives the bus and controls the monitor
// slave  : the monitor itself
// ---------------------------------------------------------------------------
interface gpio_pulse_monitor_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16,
   parameter int IVL_W = 32
);
   logic             start;
   logic             abort;
   logic [WIDTH-1:0] bus_in;
   logic             event_valid;
   logic [WIDTH-1:0] event_data;
   logic [CNT_W-1:0] event_index;
   logic [IVL_W-1:0] event_interval;
   logic             busy;
   logic             pass;
   logic             fail;

   modport master (
      output start, abort, bus_in,
      input  event_valid, event_data, event_index, event_interval,
      input  busy, pass, fail
   );

   modport slave (
      input  start, abort, bus_in,
      output event_valid, event_data, event_index, event_interval,
      output busy, pass, fail
   );
endinterface

// File: rtl/gpio_pulse_monitor.sv
// ---------------------------------------------------------------------------
// gpio_pulse_monitor
//
// Counts value changes on a WIDTH-bit GPIO/LED bus after an arm request and
// reports each counted change with its ordinal and the number of cycles since
// the previous counted change. Declares pass after TARGET changes, or fail if
// the bus stays quiet for TIMEOUT_CYCLES cycles (0 disables the timeout).
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous reset, active low
//   mon  : gpio_pulse_monitor_if.slave
//          start/abort/bus_in in; event_valid/event_data/event_index/
//          event_interval/busy/pass/fail out (all registered)
//
// Parameters:
//   WIDTH          monitored bus width (1..32)
//   TARGET         counted changes required for pass
//   CNT_W          width of change counter / event_index
//   TIMEOUT_CYCLES max quiet cycles before fail, 0 = never fail
//   SYNC_STAGES    input synchroniser depth, 0 = bus used directly
//   SKIP_FIRST     1 = first change after arm only re-baselines
//   IVL_W          width of event_interval
// ---------------------------------------------------------------------------
module gpio_pulse_monitor #(
   parameter int WIDTH          = 8,
   parameter int TARGET         = 10,
   parameter int CNT_W          = 16,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int SYNC_STAGES    = 2,
   parameter int SKIP_FIRST     = 1,
   parameter int IVL_W          = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   gpio_pulse_monitor_if.slave  mon
);

   // Timer only needs to reach TIMEOUT_CYCLES, where it parks.
   localparam int TMR_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMR_W-1:0] TMR_MAX    = TMR_W'(TIMEOUT_CYCLES);
   localparam logic             TMO_EN     = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(TARGET);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARM   = 3'd1,
      COUNT = 3'd2,
      DONE  = 3'd3,
      FAIL  = 3'd4
   } state_t;

   // Armed state depends on whether the first change is a re-baseline.
   localparam state_t ARM_STATE = (SKIP_FIRST != 0) ? ARM : COUNT;

   state_t           state;
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] prev;
   logic [CNT_W-1:0] count;
   logic [TMR_W-1:0] timer;
   logic [IVL_W-1:0] interval;

   logic             ev_valid_p0;
   logic [WIDTH-1:0] ev_data_p0;
   logic [CNT_W-1:0] ev_index_p0;
   logic [IVL_W-1:0] ev_ivl_p0;
   logic             busy_p0;
   logic             pass_p0;
   logic             fail_p0;

   logic             active;
   logic             change;
   logic             timeout;
   logic [CNT_W-1:0] count_inc;

   // ------------------------------------------------------------------
   // Saturating increments
   // ------------------------------------------------------------------
   function automatic logic [IVL_W-1:0] ivl_sat_inc(input logic [IVL_W-1:0] v);
      return (&v) ? v : v + IVL_W'(1);
   endfunction

   function automatic logic [TMR_W-1:0] tmr_sat_inc(input logic [TMR_W-1:0] v);
      return (v >= TMR_MAX) ? TMR_MAX : v + TMR_W'(1);
   endfunction

   // ------------------------------------------------------------------
   // Input synchroniser stages: bus_in -> s
   // ------------------------------------------------------------------
   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign s = mon.bus_in;
      end else begin : g_sync
         logic [WIDTH-1:0] sync_p [SYNC_STAGES];

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               for (int i = 0; i < SYNC_STAGES; i++) begin
                  sync_p[i] <= '0;
               end
            end else begin
               sync_p[0] <= mon.bus_in;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  sync_p[i] <= sync_p[i-1];
               end
            end
         end

         assign s = sync_p[SYNC_STAGES-1];
      end
   endgenerate

   // A change wins over a coincident timeout, so timeout is masked by it.
   assign active    = (state == ARM) || (state == COUNT);
   assign change    = active && (s != prev);
   assign timeout   = TMO_EN && active && !change && (timer == TMR_MAX);
   assign count_inc = count + CNT_W'(1);

   // ------------------------------------------------------------------
   // Control FSM, counters and registered event/flag outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         prev        <= '0;
         count       <= '0;
         timer       <= '0;
         interval    <= '0;
         ev_valid_p0 <= 1'b0;
         ev_data_p0  <= '0;
         ev_index_p0 <= '0;
         ev_ivl_p0   <= '0;
         busy_p0     <= 1'b0;
         pass_p0     <= 1'b0;
         fail_p0     <= 1'b0;
      end else begin
         // prev follows s unconditionally so arming always baselines
         // against the current bus value.
         prev        <= s;
         ev_valid_p0 <= 1'b0;

         if (mon.abort) begin
            state       <= IDLE;
            count       <= '0;
            timer       <= '0;
            interval    <= '0;
            ev_data_p0  <= '0;
            ev_index_p0 <= '0;
            ev_ivl_p0   <= '0;
            busy_p0     <= 1'b0;
            pass_p0     <= 1'b0;
            fail_p0     <= 1'b0;
         end else begin
            case (state)
               IDLE, DONE, FAIL: begin
                  if (mon.start) begin
                     state    <= ARM_STATE;
                     count    <= '0;
                     timer    <= '0;
                     interval <= '0;
                     busy_p0  <= 1'b1;
                     pass_p0  <= 1'b0;
                     fail_p0  <= 1'b0;
                  end
               end

               ARM: begin
                  if (change) begin
                     // Re-baseline only: interval measured from here.
                     state    <= COUNT;
                     timer    <= '0;
                     interval <= '0;
                  end else if (timeout) begin
                     state   <= FAIL;
                     busy_p0 <= 1'b0;
                     fail_p0 <= 1'b1;
                  end else begin
                     timer    <= tmr_sat_inc(timer);
                     interval <= ivl_sat_inc(interval);
                  end
               end

               COUNT: begin
                  if (change) begin
                     ev_valid_p0 <= 1'b1;
                     ev_data_p0  <= s;
                     ev_index_p0 <= count_inc;
                     ev_ivl_p0   <= ivl_sat_inc(interval);
                     count       <= count_inc;
                     timer       <= '0;
                     interval    <= '0;
                     if (count_inc == CNT_TARGET) begin
                        state   <= DONE;
                        busy_p0 <= 1'b0;
                        pass_p0 <= 1'b1;
                     end
                  end else if (timeout) begin
                     state   <= FAIL;
                     busy_p0 <= 1'b0;
                     fail_p0 <= 1'b1;
                  end else begin
                     timer    <= tmr_sat_inc(timer);
                     interval <= ivl_sat_inc(interval);
                  end
               end

               default: begin
                  state   <= IDLE;
                  busy_p0 <= 1'b0;
               end
            endcase
         end
      end
   end

   assign mon.event_valid    = ev_valid_p0;
   assign mon.event_data     = ev_data_p0;
   assign mon.event_index    = ev_index_p0;
   assign mon.event_interval = ev_ivl_p0;
   assign mon.busy           = busy_p0;
   assign mon.pass           = pass_p0;
   assign mon.fail           = fail_p0;

endmodule

// File: tb/tb_gpio_pulse_monitor.sv
// ---------------------------------------------------------------------------
// tb_gpio_pulse_monitor
//
// Directed bench for gpio_pulse_monitor with three instances:
//   u0 : defaults (SKIP_FIRST=1, TARGET=10, SYNC_STAGES=2)
//   u1 : SKIP_FIRST=0, TARGET=3
//   u2 : SKIP_FIRST=0, TIMEOUT_CYCLES=20
// Inputs are driven 1 ns after a rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_gpio_pulse_monitor;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   gpio_pulse_monitor_if #(.WIDTH(8), .CNT_W(16), .IVL_W(32)) if0 ();
   gpio_pulse_monitor_if #(.WIDTH(8), .CNT_W(16), .IVL_W(32)) if1 ();
   gpio_pulse_monitor_if #(.WIDTH(8), .CNT_W(16), .IVL_W(32)) if2 ();

   gpio_pulse_monitor u0 (.clk(clk), .rst(rst_n), .mon(if0));

   gpio_pulse_monitor #(.TARGET(3), .SKIP_FIRST(0)) u1 (
      .clk(clk), .rst(rst_n), .mon(if1));

   gpio_pulse_monitor #(.TIMEOUT_CYCLES(20), .SKIP_FIRST(0)) u2 (
      .clk(clk), .rst(rst_n), .mon(if2));

   typedef struct {
      logic [31:0] data;
      logic [31:0] idx;
      logic [31:0] ivl;
   } ev_t;

   ev_t q0[$];

   // Event recorder for u0
   always @(posedge clk) begin
      #1;
      if (if0.event_valid === 1'b1)
         q0.push_back('{32'(if0.event_data), 32'(if0.event_index), if0.event_interval});
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_idle0(input string tag);
      chk({tag, "_valid"}, 32'(if0.event_valid), 0);
      chk({tag, "_data"},  32'(if0.event_data), 0);
      chk({tag, "_index"}, 32'(if0.event_index), 0);
      chk({tag, "_ivl"},   if0.event_interval, 0);
      chk({tag, "_busy"},  32'(if0.busy), 0);
      chk({tag, "_pass"},  32'(if0.pass), 0);
      chk({tag, "_fail"},  32'(if0.fail), 0);
   endtask

   initial begin
      if0.start = 0; if0.abort = 0; if0.bus_in = 8'h00;
      if1.start = 0; if1.abort = 0; if1.bus_in = 8'h00;
      if2.start = 0; if2.abort = 0; if2.bus_in = 8'h00;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk_idle0("rst");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      tick(2);

      // ---------------- Test 1: defaults, 11 toggles every 50 cycles
      if0.start = 1; tick(1); if0.start = 0;
      chk("t1_busy_arm", 32'(if0.busy), 1);
      q0.delete();
      for (int t = 0; t < 11; t++) begin
         if0.bus_in = ~if0.bus_in;
         tick(50);
      end
      chk("t1_nevents", q0.size(), 10);
      for (int k = 0; k < q0.size(); k++) begin
         chk($sformatf("t1_idx%0d", k), q0[k].idx, k + 1);
         chk($sformatf("t1_ivl%0d", k), q0[k].ivl, 50);
         // event k+1 comes from toggle k+1: even toggle count -> 0x00
         chk($sformatf("t1_data%0d", k), q0[k].data, (k % 2 == 0) ? 32'h00 : 32'hFF);
      end
      chk("t1_pass", 32'(if0.pass), 1);
      chk("t1_busy", 32'(if0.busy), 0);
      chk("t1_fail", 32'(if0.fail), 0);

      // ---------------- Test 2: SKIP_FIRST=0, TARGET=3, exact latency
      if1.start = 1; tick(1); if1.start = 0;
      tick(4);
      begin
         logic [7:0] vals [3];
         vals[0] = 8'h01; vals[1] = 8'h03; vals[2] = 8'h07;
         for (int i = 0; i < 3; i++) begin
            if1.bus_in = vals[i];
            tick(2);
            chk($sformatf("t2_early%0d", i), 32'(if1.event_valid), 0);
            tick(1);
            chk($sformatf("t2_valid%0d", i), 32'(if1.event_valid), 1);
            chk($sformatf("t2_data%0d", i),  32'(if1.event_data), 32'(vals[i]));
            chk($sformatf("t2_idx%0d", i),   32'(if1.event_index), i + 1);
            tick(1);
            chk($sformatf("t2_pulse%0d", i), 32'(if1.event_valid), 0);
            tick(5);
         end
      end
      chk("t2_pass", 32'(if1.pass), 1);
      chk("t2_busy", 32'(if1.busy), 0);

      // ---------------- Test 3: timeout 20 after two changes
      if2.start = 1; tick(1); if2.start = 0;
      tick(3);
      if2.bus_in = 8'h01;
      tick(3);
      chk("t3_ev1", 32'(if2.event_valid), 1);
      tick(5);
      if2.bus_in = 8'h03;
      tick(3);
      chk("t3_ev2", 32'(if2.event_valid), 1);
      chk("t3_idx2", 32'(if2.event_index), 2);
      tick(20);
      chk("t3_fail_early", 32'(if2.fail), 0);
      tick(1);
      chk("t3_fail", 32'(if2.fail), 1);
      chk("t3_pass", 32'(if2.pass), 0);
      chk("t3_busy", 32'(if2.busy), 0);
      chk("t3_idx_hold", 32'(if2.event_index), 2);

      // ---------------- Test 4: change coincident with timer == 20
      if2.start = 1; tick(1); if2.start = 0;
      if2.bus_in = 8'h07;
      tick(3);
      chk("t4_ev1", 32'(if2.event_valid), 1);
      chk("t4_idx1", 32'(if2.event_index), 1);
      tick(18);
      if2.bus_in = 8'h0F;   // detected on the edge where the timer is at 20
      tick(3);
      chk("t4_ev2", 32'(if2.event_valid), 1);
      chk("t4_idx2", 32'(if2.event_index), 2);
      chk("t4_nofail", 32'(if2.fail), 0);
      tick(20);
      chk("t4_fail_early", 32'(if2.fail), 0);
      tick(1);
      chk("t4_fail", 32'(if2.fail), 1);

      // ---------------- Test 5: start ignored in COUNT, abort, re-start
      if0.start = 1; tick(1); if0.start = 0;
      q0.delete();
      for (int t = 0; t < 5; t++) begin
         if0.bus_in = ~if0.bus_in;
         if (t == 2) begin
            if0.start = 1; tick(1); if0.start = 0;
            tick(9);
         end else begin
            tick(10);
         end
      end
      chk("t5_nevents", q0.size(), 4);
      for (int k = 0; k < q0.size(); k++)
         chk($sformatf("t5_idx%0d", k), q0[k].idx, k + 1);
      chk("t5_busy", 32'(if0.busy), 1);
      chk("t5_index4", 32'(if0.event_index), 4);
      if0.abort = 1; tick(1); if0.abort = 0;
      chk_idle0("t5_abort");
      if0.abort = 1; if0.start = 1; tick(1);
      if0.abort = 0; if0.start = 0;
      chk("t5_abort_start_busy", 32'(if0.busy), 0);
      if0.start = 1; tick(1); if0.start = 0;
      q0.delete();
      for (int t = 0; t < 2; t++) begin
         if0.bus_in = ~if0.bus_in;
         tick(10);
      end
      chk("t5_restart_n", q0.size(), 1);
      if (q0.size() > 0) begin
         chk("t5_restart_idx", q0[0].idx, 1);
         chk("t5_restart_ivl", q0[0].ivl, 10);
      end

      // ---------------- Test 6: async reset mid-COUNT
      if0.bus_in = ~if0.bus_in;
      tick(10);
      chk("t6_idx2", 32'(if0.event_index), 2);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_idle0("t6_rst");
      @(negedge clk);
      rst_n = 1'b1;
      tick(1);
      q0.delete();
      for (int t = 0; t < 2; t++) begin
         if0.bus_in = ~if0.bus_in;
         tick(10);
      end
      chk("t6_no_events", q0.size(), 0);
      chk("t6_busy", 32'(if0.busy), 0);
      chk("t6_index", 32'(if0.event_index), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
